// File: rtl/rtc_pkg.sv
// Shared constants and types for the RTC configuration writer: RTC register
// addresses, transfer command codes, config-mode encodings and phase types.
package rtc_pkg;

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] ADDR_SS   = 8'h21;
    localparam logic [7:0] ADDR_MM   = 8'h22;
    localparam logic [7:0] ADDR_HH   = 8'h23;
    localparam logic [7:0] ADDR_DAY  = 8'h24;
    localparam logic [7:0] ADDR_MES  = 8'h25;
    localparam logic [7:0] ADDR_YEAR = 8'h26;
    localparam logic [7:0] ADDR_SS_T = 8'h41;
    localparam logic [7:0] ADDR_MM_T = 8'h42;
    localparam logic [7:0] ADDR_HH_T = 8'h43;

    localparam logic [7:0] CMD_TIME_DATE = 8'hF1;
    localparam logic [7:0] CMD_TIMER     = 8'hF2;

    localparam logic [1:0] MODE_NORMAL = 2'd0;
    localparam logic [1:0] MODE_TIME   = 2'd1;
    localparam logic [1:0] MODE_DATE   = 2'd2;
    localparam logic [1:0] MODE_TIMER  = 2'd3;

    typedef enum logic {PH_ADDR = 1'b0, PH_DATA = 1'b1} phase_t;

    // GRP_INIT is the power-up control-register sequence (two writes to 0x00).
    typedef enum logic [1:0] {GRP_TIME, GRP_DATE, GRP_TIMER, GRP_INIT} grp_t;

    // RTC register address for the idx-th write (0..2) of a group.
    function automatic logic [7:0] reg_addr(grp_t grp, logic [1:0] idx);
        logic [7:0] a;
        a = ADDR_CTRL;
        unique case (grp)
            GRP_TIME:  a = (idx == 2'd0) ? ADDR_SS  : (idx == 2'd1) ? ADDR_MM  : ADDR_HH;
            GRP_DATE:  a = (idx == 2'd0) ? ADDR_DAY : (idx == 2'd1) ? ADDR_MES : ADDR_YEAR;
            GRP_TIMER: a = (idx == 2'd0) ? ADDR_SS_T : (idx == 2'd1) ? ADDR_MM_T : ADDR_HH_T;
            default:   a = ADDR_CTRL;
        endcase
        return a;
    endfunction

    function automatic logic [7:0] grp_cmd(grp_t grp);
        return (grp == GRP_TIMER) ? CMD_TIMER : CMD_TIME_DATE;
    endfunction

endpackage

// File: rtl/rtc_config_writer_if.sv
// RTC pad bus: multiplexed address/data byte plus its strobes.
interface rtc_config_writer_if;
    logic [7:0] rtc_ad_out;
    logic       rtc_ad_oe;
    logic       rtc_cs_n;
    logic       rtc_wr_n;
    logic       rtc_rd_n;
    logic       rtc_a_d;

    modport master (output rtc_ad_out, rtc_ad_oe, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d);
    modport slave  (input  rtc_ad_out, rtc_ad_oe, rtc_cs_n, rtc_wr_n, rtc_rd_n, rtc_a_d);
endinterface

// File: rtl/rtc_bus_cycle.sv
// One RTC bus phase (address or data): SETUP -> STROBE -> HOLD -> GAP, each
// stage timed by a down-counter. A start presented on the last GAP clock
// launches the next phase back-to-back, so CS_n stays high exactly T_GAP clocks.
module rtc_bus_cycle
    import rtc_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  phase_t     ph_type,
    input  logic [7:0] ph_byte,
    rtc_config_writer_if.master rtc,
    output logic       cycle_done
);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_GAP} stage_t;

    stage_t     stage;
    logic [7:0] cnt;

    // This block only ever writes to the RTC.
    assign rtc.rtc_rd_n = 1'b1;
    assign cycle_done   = (stage == S_GAP) && (cnt == 8'd0);

    // Stage sequencing and registered pad outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            stage          <= S_IDLE;
            cnt            <= 8'd0;
            rtc.rtc_cs_n   <= 1'b1;
            rtc.rtc_wr_n   <= 1'b1;
            rtc.rtc_ad_oe  <= 1'b0;
            rtc.rtc_a_d    <= 1'b0;
            rtc.rtc_ad_out <= 8'h00;
        end else if (start) begin
            stage          <= S_SETUP;
            cnt            <= 8'(T_SETUP - 1);
            rtc.rtc_cs_n   <= 1'b0;
            rtc.rtc_wr_n   <= 1'b1;
            rtc.rtc_ad_oe  <= 1'b1;
            rtc.rtc_a_d    <= (ph_type == PH_DATA);
            rtc.rtc_ad_out <= ph_byte;
        end else if (stage != S_IDLE) begin
            if (cnt != 8'd0) begin
                cnt <= cnt - 8'd1;
            end else begin
                unique case (stage)
                    S_SETUP: begin
                        stage        <= S_STROBE;
                        cnt          <= 8'(T_PULSE - 1);
                        rtc.rtc_wr_n <= 1'b0;
                    end
                    S_STROBE: begin
                        stage        <= S_HOLD;
                        cnt          <= 8'(T_HOLD - 1);
                        rtc.rtc_wr_n <= 1'b1;
                    end
                    S_HOLD: begin
                        stage         <= S_GAP;
                        cnt           <= 8'(T_GAP - 1);
                        rtc.rtc_cs_n  <= 1'b1;
                        rtc.rtc_ad_oe <= 1'b0;
                    end
                    default: stage <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/rtc_config_writer.sv
// RTC configuration writer. Snapshots the edited BCD group when a config mode
// is left and writes it to the RTC (3 register writes, then a command byte).
// Commits arriving while busy wait in a one-deep, latest-wins pending slot.
// Optional build macro RTC_INIT_EN: after reset, write 0x10 then 0x00 to RTC
// address 0x00 before serving any commit.
//
// state | meaning
// IDLE  | waiting for a pending commit
// LOAD  | shadow loaded, first address phase launched
// REG0  | first register write (A then D)
// REG1  | second register write
// REG2  | third register write
// CMD   | command byte (address phase only)
// FIN   | done pulse; chains straight into LOAD if a commit is pending
module rtc_config_writer
    import rtc_pkg::*;
#(
    parameter int T_SETUP = 2,
    parameter int T_PULSE = 4,
    parameter int T_HOLD  = 2,
    parameter int T_GAP   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] config_mode,
    input  logic [7:0] btn_data_SS,
    input  logic [7:0] btn_data_MM,
    input  logic [7:0] btn_data_HH,
    input  logic [7:0] btn_data_YEAR,
    input  logic [7:0] btn_data_MES,
    input  logic [7:0] btn_data_DAY,
    input  logic [7:0] btn_data_SS_T,
    input  logic [7:0] btn_data_MM_T,
    input  logic [7:0] btn_data_HH_T,
    rtc_config_writer_if.master rtc,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {ST_IDLE, ST_LOAD, ST_REG0, ST_REG1, ST_REG2, ST_CMD, ST_FIN} state_t;

    state_t          state, nxt_state;
    phase_t          cur_ph, nxt_ph, bus_type;
    logic            nxt_valid;
    logic [1:0]      prev_mode, nxt_idx;
    logic            commit, start, cycle_done;
    grp_t            snap_grp, pend_grp, sh_grp;
    logic [2:0][7:0] snap_data, pend_data, sh_data;
    logic            pend_valid;
    logic [7:0]      bus_byte;
`ifdef RTC_INIT_EN
    logic            init_req;
`endif

    assign commit = (prev_mode != MODE_NORMAL) && (config_mode != prev_mode);
    assign busy   = (state != ST_IDLE) || pend_valid;
    assign start  = (state == ST_LOAD) || (cycle_done && nxt_valid);

    // Select the group being left; element 0 is written first.
    always_comb begin
        snap_grp  = GRP_TIME;
        snap_data = {btn_data_HH, btn_data_MM, btn_data_SS};
        unique case (prev_mode)
            MODE_TIME: begin
                snap_grp  = GRP_TIME;
                snap_data = {btn_data_HH, btn_data_MM, btn_data_SS};
            end
            MODE_DATE: begin
                snap_grp  = GRP_DATE;
                snap_data = {btn_data_YEAR, btn_data_MES, btn_data_DAY};
            end
            MODE_TIMER: begin
                snap_grp  = GRP_TIMER;
                snap_data = {btn_data_HH_T, btn_data_MM_T, btn_data_SS_T};
            end
            default: ;
        endcase
    end

    // Next bus phase after the current one; nxt_valid=0 means the sequence ends.
    always_comb begin
        nxt_state = state;
        nxt_ph    = PH_ADDR;
        nxt_valid = 1'b0;
        unique case (state)
            ST_LOAD: begin
                nxt_state = ST_REG0;
                nxt_valid = 1'b1;
            end
            ST_REG0, ST_REG1, ST_REG2: begin
                if (cur_ph == PH_ADDR) begin
                    nxt_ph    = PH_DATA;
                    nxt_valid = 1'b1;
                end else if (state == ST_REG0) begin
                    nxt_state = ST_REG1;
                    nxt_valid = 1'b1;
                end else if (state == ST_REG1) begin
                    nxt_state = ST_REG2;
                    nxt_valid = (sh_grp != GRP_INIT);
                end else begin
                    nxt_state = ST_CMD;
                    nxt_valid = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Type and byte of the phase being launched.
    always_comb begin
        unique case (nxt_state)
            ST_REG1: nxt_idx = 2'd1;
            ST_REG2: nxt_idx = 2'd2;
            default: nxt_idx = 2'd0;
        endcase
        bus_type = nxt_ph;
        if (nxt_state == ST_CMD) begin
            bus_type = PH_ADDR;
            bus_byte = grp_cmd(sh_grp);
        end else if (nxt_ph == PH_DATA) begin
            bus_byte = sh_data[nxt_idx];
        end else begin
            bus_byte = reg_addr(sh_grp, nxt_idx);
        end
    end

    // Sequencer FSM with commit detect and the pending slot.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            cur_ph     <= PH_ADDR;
            prev_mode  <= MODE_NORMAL;
            pend_valid <= 1'b0;
            pend_grp   <= GRP_TIME;
            pend_data  <= '0;
            sh_grp     <= GRP_TIME;
            sh_data    <= '0;
            done       <= 1'b0;
`ifdef RTC_INIT_EN
            init_req   <= 1'b1;
`endif
        end else begin
            done      <= 1'b0;
            prev_mode <= config_mode;
            unique case (state)
                ST_IDLE: begin
`ifdef RTC_INIT_EN
                    if (init_req) begin
                        init_req <= 1'b0;
                        sh_grp   <= GRP_INIT;
                        sh_data  <= {8'h00, 8'h00, 8'h10};
                        state    <= ST_LOAD;
                    end else
`endif
                    if (pend_valid) begin
                        sh_grp     <= pend_grp;
                        sh_data    <= pend_data;
                        pend_valid <= 1'b0;
                        state      <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    state  <= nxt_state;
                    cur_ph <= nxt_ph;
                end
                ST_REG0, ST_REG1, ST_REG2, ST_CMD: begin
                    if (cycle_done) begin
                        if (nxt_valid) begin
                            state  <= nxt_state;
                            cur_ph <= nxt_ph;
                        end else if (sh_grp == GRP_INIT) begin
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_FIN: begin
                    if (pend_valid) begin
                        sh_grp     <= pend_grp;
                        sh_data    <= pend_data;
                        pend_valid <= 1'b0;
                        state      <= ST_LOAD;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            // A fresh commit always lands in the slot, overriding any consume above.
            if (commit) begin
                pend_valid <= 1'b1;
                pend_grp   <= snap_grp;
                pend_data  <= snap_data;
            end
        end
    end

    rtc_bus_cycle #(
        .T_SETUP (T_SETUP),
        .T_PULSE (T_PULSE),
        .T_HOLD  (T_HOLD),
        .T_GAP   (T_GAP)
    ) u_bus (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .ph_type    (bus_type),
        .ph_byte    (bus_byte),
        .rtc        (rtc),
        .cycle_done (cycle_done)
    );

endmodule
